// File: rtl/led_fade_driver.sv
// led_fade_driver: per-LED brightness fade with 16-step PWM; ports clk_24m, rst (async high), led_in[15:0], led_out[15:0]; `LED_ACTIVE_LOW_EN inverts led_out
module led_fade_driver #(
  parameter int DECAY_DIV = 375000
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic [15:0] led_in,
  output logic [15:0] led_out
);
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [15:0] POL = 16'hFFFF;
`else
  localparam logic [15:0] POL = 16'h0000;
`endif
  logic [3:0]    r_bright [16];
  logic [3:0]    r_pwm;
  logic [DW-1:0] r_dcnt;
  logic [15:0]   r_led;
  logic          w_tick;
  logic [15:0]   w_on;
  assign w_tick  = r_dcnt == DW'(DECAY_DIV - 1);
  assign led_out = r_led;
  for (genvar g = 0; g < 16; g++) begin : g_on
    assign w_on[g] = (r_bright[g] == 4'hF) || (r_pwm < r_bright[g]);
  end
  always_ff @(posedge clk_24m or posedge rst)
    if (rst) begin
      r_pwm  <= '0;
      r_dcnt <= '0;
      r_led  <= POL;
      for (int i = 0; i < 16; i++) r_bright[i] <= '0;
    end else begin
      r_pwm  <= r_pwm + 4'd1;
      r_dcnt <= w_tick ? '0 : r_dcnt + DW'(1);
      r_led  <= w_on ^ POL;
      for (int i = 0; i < 16; i++)
        r_bright[i] <= led_in[i] ? 4'hF : (w_tick && r_bright[i] != 4'd0) ? r_bright[i] - 4'd1 : r_bright[i];
    end
endmodule
